// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath types and cache arbiter state encoding
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;

    // Arbiter FSM: one idle state between every grant, one grant state per client.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GRANT_I = 2'b01,
        ARB_GRANT_D = 2'b10
    } arb_state_t;

    // Encoding of the last_served register.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-client (I-cache / D-cache) physical memory arbiter
//
// Purpose: shares one physical memory port between the instruction cache and
// the data cache. Under contention the grant alternates, and every grant is
// separated from the next by one IDLE cycle.
//
// Ports:
//   clk             sole clock, all state on the rising edge
//   reset           asynchronous, active-low reset
//   i_pmem_read     I-cache block read request
//   i_pmem_address  I-cache block address
//   i_pmem_rdata    read block returned to the I-cache (pmem_rdata forwarded)
//   i_pmem_resp     I-cache transaction complete
//   d_pmem_read     D-cache block read request
//   d_pmem_write    D-cache writeback request
//   d_pmem_address  D-cache block address
//   d_pmem_wdata    D-cache writeback block
//   d_pmem_rdata    read block returned to the D-cache (pmem_rdata forwarded)
//   d_pmem_resp     D-cache transaction complete
//   pmem_read       read strobe to physical memory
//   pmem_write      write strobe to physical memory
//   pmem_address    address to physical memory
//   pmem_wdata      write block to physical memory
//   pmem_rdata      read block from physical memory
//   pmem_resp       transaction complete from physical memory
//
// Parameter D_FIRST selects which client wins a simultaneous request right
// after reset (1 = D-cache, 0 = I-cache).
module cache_arbiter
    import lc3b_types::*;
#(
    parameter logic D_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      reset,

    input  logic      i_pmem_read,
    input  lc3b_word  i_pmem_address,
    output lc3b_block i_pmem_rdata,
    output logic      i_pmem_resp,

    input  logic      d_pmem_read,
    input  logic      d_pmem_write,
    input  lc3b_word  d_pmem_address,
    input  lc3b_block d_pmem_wdata,
    output lc3b_block d_pmem_rdata,
    output logic      d_pmem_resp,

    output logic      pmem_read,
    output logic      pmem_write,
    output lc3b_word  pmem_address,
    output lc3b_block pmem_wdata,
    input  lc3b_block pmem_rdata,
    input  logic      pmem_resp
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_served;
    logic       last_next;

    logic       i_req;
    logic       d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // last_served starts on the client that should lose the first tie, so the
    // D_FIRST client wins it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARB_IDLE;
            last_served <= D_FIRST ? LAST_I : LAST_D;
        end else begin
            state       <= state_next;
            last_served <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last_served;
        case (state)
            ARB_IDLE: begin
                // D wins when alone, or on a tie when I was served last.
                if (d_req && (!i_req || last_served == LAST_I)) begin
                    state_next = ARB_GRANT_D;
                end else if (i_req) begin
                    state_next = ARB_GRANT_I;
                end
            end
            ARB_GRANT_I: begin
                if (pmem_resp) begin
                    state_next = ARB_IDLE;
                    last_next  = LAST_I;
                end else if (!i_req) begin
                    // Abandoned request: release the port, fairness unchanged.
                    state_next = ARB_IDLE;
                end
            end
            ARB_GRANT_D: begin
                if (pmem_resp) begin
                    state_next = ARB_IDLE;
                    last_next  = LAST_D;
                end else if (!d_req) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Read data goes to both clients unconditionally; only the resp strobe
    // tells a client that the data is its own.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state)
            ARB_GRANT_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            ARB_GRANT_D: begin
                // A simultaneous read+write is passed through untouched.
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter
module tb_cache_arbiter;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       i_pmem_read;
    lc3b_word   i_pmem_address;
    lc3b_block  i_pmem_rdata;
    logic       i_pmem_resp;
    logic       d_pmem_read;
    logic       d_pmem_write;
    lc3b_word   d_pmem_address;
    lc3b_block  d_pmem_wdata;
    lc3b_block  d_pmem_rdata;
    logic       d_pmem_resp;
    logic       pmem_read;
    logic       pmem_write;
    lc3b_word   pmem_address;
    lc3b_block  pmem_wdata;
    lc3b_block  pmem_rdata;
    logic       pmem_resp;

    cache_arbiter #(.D_FIRST(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    typedef struct {
        logic [15:0]  addr;
        logic         wr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } txn_t;

    txn_t q_i[$];
    txn_t q_d[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [127:0] mem_data(input logic [15:0] a);
        logic [127:0] k;
        k = {4{32'h9E3779B9}};
        return {8{a}} ^ k;
    endfunction

    // ---------------- monitor / reference model ----------------
    int          m_owner = 0;   // 0 none, 1 I, 2 D
    bit          m_last  = 0;   // 0 I served last, 1 D served last
    int          cyc     = 0;
    bit          prev_active = 0;
    bit          i_resp_seen = 0;
    bit          d_resp_seen = 0;
    logic [15:0] grant_addr[$];
    int          grant_cyc[$];
    int          d_resp_cyc  = 0;
    int          i_resp_cnt  = 0;
    int          d_resp_cnt  = 0;
    int          write_cycles = 0;
    txn_t        t_mon;

    always @(negedge clk) begin
        cyc++;
        i_resp_seen = i_pmem_resp;
        d_resp_seen = d_pmem_resp;
        chk("i_rdata_fwd", 160'(i_pmem_rdata), 160'(pmem_rdata));
        chk("d_rdata_fwd", 160'(d_pmem_rdata), 160'(pmem_rdata));
        if (!reset) begin
            chk("reset_outputs",
                160'({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata}), 160'(0));
            m_owner = 0;
            m_last = 0;
            prev_active = 0;
        end else begin
            if ((pmem_read || pmem_write) && !prev_active) begin
                grant_addr.push_back(pmem_address);
                grant_cyc.push_back(cyc);
            end
            prev_active = pmem_read || pmem_write;
            if (i_pmem_resp) i_resp_cnt++;
            if (d_pmem_resp) begin
                d_resp_cnt++;
                d_resp_cyc = cyc;
            end
            if (pmem_write) write_cycles++;
            case (m_owner)
                0: begin
                    chk("idle_outputs",
                        160'({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata}), 160'(0));
                    if (i_pmem_read && (d_pmem_read || d_pmem_write)) m_owner = m_last ? 1 : 2;
                    else if (d_pmem_read || d_pmem_write) m_owner = 2;
                    else if (i_pmem_read) m_owner = 1;
                end
                1: begin
                    chk("grant_i_bus", 160'({pmem_read, pmem_write, pmem_address, pmem_wdata}),
                        160'({i_pmem_read, 1'b0, i_pmem_address, 128'd0}));
                    chk("grant_i_resp", 160'({i_pmem_resp, d_pmem_resp}), 160'({pmem_resp, 1'b0}));
                    if (pmem_resp) begin
                        if (q_i.size() == 0) chk("i_unexpected_resp", 160'(1), 160'(0));
                        else begin
                            t_mon = q_i.pop_front();
                            chk("i_txn_addr", 160'(pmem_address), 160'(t_mon.addr));
                            chk("i_txn_rdata", 160'(i_pmem_rdata), 160'(t_mon.rdata));
                        end
                        m_last = 0;
                        m_owner = 0;
                    end else if (!i_pmem_read) m_owner = 0;
                end
                default: begin
                    chk("grant_d_bus", 160'({pmem_read, pmem_write, pmem_address, pmem_wdata}),
                        160'({d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata}));
                    chk("grant_d_resp", 160'({i_pmem_resp, d_pmem_resp}), 160'({1'b0, pmem_resp}));
                    if (pmem_resp) begin
                        if (q_d.size() == 0) chk("d_unexpected_resp", 160'(1), 160'(0));
                        else begin
                            t_mon = q_d.pop_front();
                            chk("d_txn", 160'({pmem_write, pmem_address, pmem_wdata}),
                                160'({t_mon.wr, t_mon.addr, t_mon.wdata}));
                            chk("d_txn_rdata", 160'(d_pmem_rdata), 160'(t_mon.rdata));
                        end
                        m_last = 1;
                        m_owner = 0;
                    end else if (!(d_pmem_read || d_pmem_write)) m_owner = 0;
                end
            endcase
        end
    end

    // ---------------- stimulus: clients and memory ----------------
    bit rand_mode = 0;
    bit i_active = 0, d_active = 0;
    int i_abort = 0, d_abort = 0, i_gap = 0, d_gap = 0;
    int i_auto = 0, d_auto = 0, i_done = 0, d_done = 0;
    int seq_i = 0, seq_d = 0;
    int mem_lat = 2, mem_cnt = 0;

    task automatic issue_i(input logic [15:0] a);
        txn_t t;
        t.addr = a; t.wr = 1'b0; t.wdata = '0; t.rdata = mem_data(a);
        q_i.push_back(t);
        i_pmem_read = 1'b1;
        i_pmem_address = a;
        i_active = 1;
        i_abort = 0;
        if (rand_mode && $urandom_range(0, 7) == 0) i_abort = $urandom_range(1, 4);
    endtask

    task automatic issue_d(input logic [15:0] a, input logic wr, input logic [127:0] wd);
        txn_t t;
        t.addr = a; t.wr = wr; t.wdata = wd; t.rdata = mem_data(a);
        q_d.push_back(t);
        d_pmem_read = !wr;
        d_pmem_write = wr;
        d_pmem_address = a;
        d_pmem_wdata = wd;
        d_active = 1;
        d_abort = 0;
        if (rand_mode && $urandom_range(0, 7) == 0) d_abort = $urandom_range(1, 4);
    endtask

    task automatic drive_clients();
        if (i_active) begin
            if (i_resp_seen) begin
                i_active = 0; i_pmem_read = 1'b0; i_done++;
                i_gap = rand_mode ? $urandom_range(0, 2) : 0;
            end else if (i_abort > 0) begin
                i_abort--;
                if (i_abort == 0) begin
                    i_active = 0; i_pmem_read = 1'b0;
                    q_i.delete(q_i.size() - 1);
                end
            end
        end
        if (d_active) begin
            if (d_resp_seen) begin
                d_active = 0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_done++;
                d_gap = rand_mode ? $urandom_range(0, 2) : 0;
            end else if (d_abort > 0) begin
                d_abort--;
                if (d_abort == 0) begin
                    d_active = 0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
                    q_d.delete(q_d.size() - 1);
                end
            end
        end
        if (!i_active) begin
            if (i_auto > 0) begin
                i_auto--; seq_i++;
                issue_i(16'h1000 + 16'(seq_i));
            end else if (rand_mode) begin
                if (i_gap > 0) i_gap--;
                else if ($urandom_range(0, 2) == 0) issue_i(16'($urandom_range(0, 65535)));
            end
        end
        if (!d_active) begin
            if (d_auto > 0) begin
                d_auto--; seq_d++;
                issue_d(16'h2000 + 16'(seq_d), 1'b0, {4{$urandom}});
            end else if (rand_mode) begin
                if (d_gap > 0) d_gap--;
                else if ($urandom_range(0, 2) == 0)
                    issue_d(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                            {$urandom, $urandom, $urandom, $urandom});
            end
        end
    endtask

    task automatic drive_mem();
        pmem_resp = 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (pmem_read || pmem_write) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                pmem_resp = 1'b1;
                pmem_rdata = mem_data(pmem_address);
                mem_cnt = 0;
                if (rand_mode) mem_lat = $urandom_range(1, 4);
            end
        end else mem_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1 drive_clients();
        #1 drive_mem();
    endtask

    task automatic clear_logs();
        grant_addr.delete();
        grant_cyc.delete();
        i_resp_cnt = 0; d_resp_cnt = 0; write_cycles = 0;
        i_done = 0; d_done = 0;
    endtask

    task automatic run_until_done(input int ti, input int td, input int budget, input string name);
        int n;
        n = 0;
        while ((i_done < ti || d_done < td) && n < budget) begin
            step();
            n++;
        end
        chk(name, 160'(i_done >= ti && d_done >= td), 160'(1));
    endtask

    initial begin
        int n;
        reset = 1'b0;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Simultaneous requests after reset: D first, then I after an IDLE cycle.
        clear_logs();
        mem_lat = 3;
        issue_i(16'h1230);
        issue_d(16'h4560, 1'b0, 128'h0);
        run_until_done(1, 1, 60, "req035_done");
        chk("req035_grants", 160'(grant_addr.size()), 160'(2));
        if (grant_addr.size() >= 2) begin
            chk("req035_first_d", 160'(grant_addr[0]), 160'(16'h4560));
            chk("req035_second_i", 160'(grant_addr[1]), 160'(16'h1230));
            chk("req037_i_after_d_resp", 160'(grant_cyc[1] - d_resp_cyc), 160'(2));
        end
        chk("req035_resp_counts", 160'({i_resp_cnt, d_resp_cnt}), 160'({32'd1, 32'd1}));

        // Continuous contention: grants alternate D,I,D,I,D,I.
        clear_logs();
        mem_lat = 2;
        i_auto = 3; d_auto = 3;
        run_until_done(3, 3, 200, "req038_done");
        chk("req038_grants", 160'(grant_addr.size()), 160'(6));
        for (int k = 0; k < 6 && k < grant_addr.size(); k++)
            chk($sformatf("req038_grant%0d", k), 160'(grant_addr[k][15:12]), 160'((k % 2 == 0) ? 2 : 1));

        // D writeback with 5-cycle memory latency.
        clear_logs();
        mem_lat = 5;
        issue_d(16'h8000, 1'b1, {16{8'hA5}});
        run_until_done(0, 1, 60, "req036_done");
        chk("req036_write_cycles", 160'(write_cycles), 160'(5));
        chk("req036_d_resp_pulses", 160'(d_resp_cnt), 160'(1));
        chk("req036_i_resp_quiet", 160'(i_resp_cnt), 160'(0));

        // D abandons its grant; pending I is granted after one IDLE cycle.
        clear_logs();
        mem_lat = 20;
        issue_d(16'h2040, 1'b0, 128'h0);
        n = 0;
        while (!(pmem_read && pmem_address == 16'h2040) && n < 10) begin
            step();
            n++;
        end
        chk("req039_d_granted", 160'({pmem_read, pmem_address}), 160'({1'b1, 16'h2040}));
        issue_i(16'h1050);
        step();
        d_abort = 1;
        step();
        step();
        chk("req039_idle", 160'({pmem_read, pmem_write, pmem_address}), 160'(0));
        step();
        chk("req039_i_grant", 160'({pmem_read, pmem_address}), 160'({1'b1, 16'h1050}));
        mem_lat = 2;
        run_until_done(1, 0, 60, "req039_i_done");

        // Asynchronous reset in the middle of a D writeback.
        clear_logs();
        mem_lat = 20;
        issue_d(16'h3000, 1'b1, {4{32'h12345678}});
        repeat (3) step();
        chk("req034_write_granted", 160'(pmem_write), 160'(1));
        #1 reset = 1'b0;
        #1 chk("req034_async_clear", 160'({pmem_read, pmem_write, pmem_address, pmem_wdata}), 160'(0));
        d_active = 0; d_abort = 0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        q_d.delete();
        repeat (2) step();
        reset = 1'b1;
        repeat (4) step();
        chk("req034_stays_idle", 160'({pmem_read, pmem_write, pmem_address}), 160'(0));

        // Randomized traffic against the reference model.
        clear_logs();
        rand_mode = 1;
        mem_lat = $urandom_range(1, 4);
        repeat (4000) step();
        rand_mode = 0;
        n = 0;
        while ((i_active || d_active) && n < 300) begin
            step();
            n++;
        end
        chk("random_drain", 160'({i_active, d_active}), 160'(0));
        repeat (3) step();
        chk("random_queues_empty", 160'({q_i.size(), q_d.size()}), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
